// File: rtl/calcn_pkg.sv
// calcn_pkg: shared definitions for the N-port calculator core.
//   - command and response codes
//   - capture FSM state encoding
//   - queue-entry and ALU-result structs (sized for the widest legal build)
//   - calc_result(): computes {resp,data} for one queued entry
// Optional feature macro: CALCN_ROT_EN (enables cmd 3, rotate-left).
package calcn_pkg;

   localparam int MAX_DATA_W = 64;
   localparam int MAX_TAG_W  = 8;

   localparam logic [3:0] CMD_NOP = 4'd0;
   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_ROL = 4'd3;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;

   localparam logic [1:0] RESP_NONE = 2'b00;
   localparam logic [1:0] RESP_OK   = 2'b01;
   localparam logic [1:0] RESP_ERR  = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OP2  = 1'b1
   } cap_state_t;

   // Entries are zero-extended into these fields; the active width is
   // passed to calc_result so carries and masks follow DATA_W.
   typedef struct packed {
      logic [3:0]            cmd;
      logic [MAX_TAG_W-1:0]  tag;
      logic [MAX_DATA_W-1:0] op1;
      logic [MAX_DATA_W-1:0] op2;
   } entry_t;

   typedef struct packed {
      logic [1:0]            resp;
      logic [MAX_TAG_W-1:0]  tag;
      logic [MAX_DATA_W-1:0] data;
   } result_t;

   // data_w must be a power of two in 8..64.
   function automatic result_t calc_result(input entry_t e, input logic [6:0] data_w);
      result_t               r;
      logic [MAX_DATA_W:0]   sum;
      logic [MAX_DATA_W-1:0] mask;
      logic [5:0]            sh;
      mask   = (data_w == 7'd64) ? {MAX_DATA_W{1'b1}} : ((64'd1 << data_w) - 64'd1);
      sum    = {1'b0, e.op1} + {1'b0, e.op2};
      // shift amount keeps only the low log2(data_w) bits of op2
      sh     = e.op2[5:0] & (data_w[5:0] - 6'd1);
      r.resp = RESP_OK;
      r.tag  = e.tag;
      r.data = {MAX_DATA_W{1'b0}};
      case (e.cmd)
         CMD_ADD: begin
            if (sum[data_w]) r.resp = RESP_ERR;
            else             r.data = sum[MAX_DATA_W-1:0] & mask;
         end
         CMD_SUB: begin
            if (e.op2 > e.op1) r.resp = RESP_ERR;
            else               r.data = e.op1 - e.op2;
         end
         CMD_SHL: r.data = (e.op1 << sh) & mask;
         CMD_SHR: r.data = e.op1 >> sh;
`ifdef CALCN_ROT_EN
         CMD_ROL: r.data = ((e.op1 << sh) | (e.op1 >> (data_w - {1'b0, sh}))) & mask;
`endif
         default: r.resp = RESP_ERR;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/calcn_port_queue.sv
// calcn_port_queue: one request port of calcn_core.
//   Two-beat capture FSM (beat 1: cmd/tag/op1, beat 2: op2), QDEPTH-entry FIFO,
//   registered full flag and sticky drop flag.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   i_cmd/i_data/i_tag  request beats from the port
//   i_drop_clr          clears o_drop_sticky (a same-cycle drop wins)
//   i_pop               head entry consumed by the arbiter
//   o_valid, o_entry    queue non-empty, head entry {cmd,tag,op1,op2}
//   o_full              registered queue-full flag
//   o_drop_sticky       set when a request arrives while full
module calcn_port_queue
   import calcn_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 2,
   parameter int QDEPTH = 4
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic [3:0]                   i_cmd,
   input  logic [DATA_W-1:0]            i_data,
   input  logic [TAG_W-1:0]             i_tag,
   input  logic                         i_drop_clr,
   input  logic                         i_pop,
   output logic                         o_valid,
   output logic [4+TAG_W+2*DATA_W-1:0]  o_entry,
   output logic                         o_full,
   output logic                         o_drop_sticky
);

   localparam int EW = 4 + TAG_W + 2*DATA_W;
   localparam int AW = $clog2(QDEPTH);
   localparam int CW = AW + 1;

   cap_state_t               r_state;
   cap_state_t               w_state_next;
   logic                     w_capture;
   logic                     w_push;
   logic                     w_drop;
   logic                     w_pop_ok;
   logic [3:0]               r_cmd;
   logic [TAG_W-1:0]         r_tag;
   logic [DATA_W-1:0]        r_op1;
   logic [QDEPTH-1:0][EW-1:0] r_mem;
   logic [AW-1:0]            r_wptr;
   logic [AW-1:0]            r_rptr;
   logic [CW-1:0]            r_count;
   logic [CW-1:0]            w_count_next;
   logic                     r_full;
   logic                     r_drop;

   // Capture FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Capture FSM next state: a request seen while full stays in IDLE.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if ((i_cmd != CMD_NOP) && !r_full) w_state_next = ST_OP2;
            else                               w_state_next = ST_IDLE;
         end
         ST_OP2:  w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Capture FSM outputs: latch beat 1, push on beat 2, or flag a drop.
   always_comb begin
      w_capture = 1'b0;
      w_push    = 1'b0;
      w_drop    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_cmd != CMD_NOP) begin
               if (r_full) w_drop    = 1'b1;
               else        w_capture = 1'b1;
            end else begin
               w_drop = 1'b0;
            end
         end
         ST_OP2:  w_push = 1'b1;
         default: w_push = 1'b0;
      endcase
   end

   // Beat-1 holding registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cmd <= 4'd0;
         r_tag <= {TAG_W{1'b0}};
         r_op1 <= {DATA_W{1'b0}};
      end else if (w_capture) begin
         r_cmd <= i_cmd;
         r_tag <= i_tag;
         r_op1 <= i_data;
      end else begin
         r_cmd <= r_cmd;
      end
   end

   assign w_pop_ok = i_pop && (r_count != {CW{1'b0}});

   // Occupancy after this cycle's push/pop.
   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop_ok})
         2'b10:   w_count_next = r_count + CW'(1);
         2'b01:   w_count_next = r_count - CW'(1);
         default: w_count_next = r_count;
      endcase
   end

   // FIFO storage, pointers, occupancy and registered full flag.
   // A push never finds the queue full: full was clear at beat 1 and only
   // pops can happen before beat 2.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mem   <= '0;
         r_wptr  <= {AW{1'b0}};
         r_rptr  <= {AW{1'b0}};
         r_count <= {CW{1'b0}};
         r_full  <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= {r_cmd, r_tag, r_op1, i_data};
            r_wptr        <= r_wptr + AW'(1);
         end else begin
            r_wptr <= r_wptr;
         end
         if (w_pop_ok) r_rptr <= r_rptr + AW'(1);
         else          r_rptr <= r_rptr;
         r_count <= w_count_next;
         r_full  <= (w_count_next == CW'(QDEPTH));
      end
   end

   // Sticky drop flag; a new drop wins over a same-cycle clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)          r_drop <= 1'b0;
      else if (w_drop)     r_drop <= 1'b1;
      else if (i_drop_clr) r_drop <= 1'b0;
      else                 r_drop <= r_drop;
   end

   assign o_valid       = (r_count != {CW{1'b0}});
   assign o_entry       = r_mem[r_rptr];
   assign o_full        = r_full;
   assign o_drop_sticky = r_drop;

endmodule

// File: rtl/calcn_core.sv
// calcn_core: N-port calculator core.
//   Per-port request queues (calcn_port_queue), round-robin arbiter issuing
//   one request per cycle into a single-cycle ALU, registered per-port
//   response outputs (nonzero only on the cycle carrying a response).
// Ports:
//   clk, reset                         clock, asynchronous active-low reset
//   req_cmd_in/req_data_in/req_tag_in  per-port request beats (flattened)
//   req_full, drop_sticky, drop_clr    per-port backpressure and drop report
//   out_resp/out_data/out_tag          per-port registered response
// Optional feature macro: CALCN_ROT_EN (cmd 3 rotate-left; else invalid).
module calcn_core
   import calcn_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 32,
   parameter int TAG_W     = 2,
   parameter int QDEPTH    = 4
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_PORTS*4-1:0]        req_cmd_in,
   input  logic [NUM_PORTS*DATA_W-1:0]   req_data_in,
   input  logic [NUM_PORTS*TAG_W-1:0]    req_tag_in,
   output logic [NUM_PORTS-1:0]          req_full,
   output logic [NUM_PORTS-1:0]          drop_sticky,
   input  logic [NUM_PORTS-1:0]          drop_clr,
   output logic [NUM_PORTS*2-1:0]        out_resp,
   output logic [NUM_PORTS*DATA_W-1:0]   out_data,
   output logic [NUM_PORTS*TAG_W-1:0]    out_tag
);

   localparam int EW = 4 + TAG_W + 2*DATA_W;
   localparam int PW = $clog2(NUM_PORTS);

   logic [NUM_PORTS-1:0]              w_q_valid;
   logic [NUM_PORTS-1:0][EW-1:0]      w_q_entry;
   logic [NUM_PORTS-1:0]              w_pop;
   logic [PW-1:0]                     r_ptr;
   logic [PW-1:0]                     w_gnt_idx;
   logic                              w_gnt_vld;
   logic [EW-1:0]                     w_sel;
   entry_t                            w_entry;
   result_t                           w_res;
   logic [DATA_W-1:0]                 w_res_data;
   logic [TAG_W-1:0]                  w_res_tag;
   logic                              w_res_bad;
   logic [1:0]                        w_alu_resp;
   logic [DATA_W-1:0]                 w_alu_data;
   logic [NUM_PORTS-1:0][1:0]         r_out_resp;
   logic [NUM_PORTS-1:0][DATA_W-1:0]  r_out_data;
   logic [NUM_PORTS-1:0][TAG_W-1:0]   r_out_tag;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      calcn_port_queue #(
         .DATA_W (DATA_W),
         .TAG_W  (TAG_W),
         .QDEPTH (QDEPTH)
      ) u_queue (
         .clk           (clk),
         .reset         (reset),
         .i_cmd         (req_cmd_in[p*4 +: 4]),
         .i_data        (req_data_in[p*DATA_W +: DATA_W]),
         .i_tag         (req_tag_in[p*TAG_W +: TAG_W]),
         .i_drop_clr    (drop_clr[p]),
         .i_pop         (w_pop[p]),
         .o_valid       (w_q_valid[p]),
         .o_entry       (w_q_entry[p]),
         .o_full        (req_full[p]),
         .o_drop_sticky (drop_sticky[p])
      );
   end

   // Round-robin pick: first non-empty queue at or after the pointer.
   always_comb begin
      logic [PW-1:0] w_cand;
      w_cand    = r_ptr;
      w_gnt_vld = 1'b0;
      w_gnt_idx = r_ptr;
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_cand = PW'((int'(r_ptr) + i) % NUM_PORTS);
         if (!w_gnt_vld && w_q_valid[w_cand]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = w_cand;
         end else begin
            w_gnt_vld = w_gnt_vld;
         end
      end
   end

   // One-hot pop towards the granted queue.
   always_comb begin
      w_pop = {NUM_PORTS{1'b0}};
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_pop[p] = w_gnt_vld && (w_gnt_idx == PW'(p));
      end
   end

   // Priority pointer moves past the granted port, holds when idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_ptr <= {PW{1'b0}};
      else if (w_gnt_vld && (w_gnt_idx == PW'(NUM_PORTS-1)))
         r_ptr <= {PW{1'b0}};
      else if (w_gnt_vld)
         r_ptr <= w_gnt_idx + PW'(1);
      else
         r_ptr <= r_ptr;
   end

   assign w_sel = w_q_entry[w_gnt_idx];

   // ALU: unpack the granted entry and evaluate it.
   always_comb begin
      w_entry.cmd = w_sel[EW-1 -: 4];
      w_entry.tag = MAX_TAG_W'(w_sel[2*DATA_W +: TAG_W]);
      w_entry.op1 = MAX_DATA_W'(w_sel[DATA_W +: DATA_W]);
      w_entry.op2 = MAX_DATA_W'(w_sel[0 +: DATA_W]);
      w_res       = calc_result(w_entry, 7'(DATA_W));
      w_res_data  = w_res.data[DATA_W-1:0];
      w_res_tag   = w_res.tag[TAG_W-1:0];
      // Defensive: anything outside the configured widths is reported as an error.
      w_res_bad   = (w_res.data != MAX_DATA_W'(w_res_data)) ||
                    (w_res.tag  != MAX_TAG_W'(w_res_tag));
      w_alu_resp  = w_res_bad ? RESP_ERR : w_res.resp;
      w_alu_data  = (w_alu_resp == RESP_OK) ? w_res_data : {DATA_W{1'b0}};
   end

   // Response registers: only the granted port carries a nonzero response.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_resp <= '0;
         r_out_data <= '0;
         r_out_tag  <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_pop[p]) begin
               r_out_resp[p] <= w_alu_resp;
               r_out_data[p] <= w_alu_data;
               r_out_tag[p]  <= w_res_tag;
            end else begin
               r_out_resp[p] <= RESP_NONE;
               r_out_data[p] <= {DATA_W{1'b0}};
               r_out_tag[p]  <= {TAG_W{1'b0}};
            end
         end
      end
   end

   assign out_resp = r_out_resp;
   assign out_data = r_out_data;
   assign out_tag  = r_out_tag;

endmodule
